// File: rtl/demux_16ch_scan_pkg.sv
// Shared constants and types for the 16-channel scan demultiplexer.
package demux_16ch_scan_pkg;

    localparam int unsigned N_CH   = 16;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned N_GRP  = 4;
    localparam int unsigned GRP_W  = 4;
    localparam int unsigned FCNT_W = 8;

    typedef enum logic {
        MODE_AUTO     = 1'b0,
        MODE_EXPLICIT = 1'b1
    } mode_e;

    // Output word viewed as four nibble groups, D most significant.
    typedef struct packed {
        logic [GRP_W-1:0] d;
        logic [GRP_W-1:0] c;
        logic [GRP_W-1:0] b;
        logic [GRP_W-1:0] a;
    } word_t;

endpackage

// File: rtl/demux_16ch_scan_1to4.sv
// 2-bit index to one-hot write-enable decoder, gated by an enable.
module demux_1to4 (
    input  logic [1:0] idx,
    input  logic       en,
    output logic [3:0] we_c
);

    // One-hot decode of idx when enabled, all zero otherwise.
    always_comb begin
        we_c = 4'b0000;
        if (en) begin
            we_c[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_16ch_scan.sv
// Rebuilds a 16-bit word (groups A..D) from a time-multiplexed serial line.
// Auto mode scans indices 0..15 into a shadow register and commits atomically;
// explicit mode writes single output bits addressed by sel_in.
module demux_16ch_scan
    import demux_16ch_scan_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       din_valid,
    input  logic       sel_mode,
    input  logic [3:0] sel_in,
    input  logic       clear,
    output logic [3:0] sel_out,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [3:0] C,
    output logic [3:0] D,
    output logic       frame_done,
    output logic [7:0] frame_count
);

    mode_e              mode;
    logic               wr_en;
    logic [SEL_W-1:0]   idx;
    logic [N_GRP-1:0]   grp_we;
    logic [N_CH-1:0]    we_c;

    logic [SEL_W-1:0]   cnt;
    logic [SEL_W-1:0]   cnt_nxt;
    logic [N_CH-1:0]    shreg;
    logic [N_CH-1:0]    shreg_nxt;
    logic [N_CH-1:0]    word_q;
    logic [N_CH-1:0]    word_nxt;
    logic               commit_c;
    logic               commit_q;
    logic               frame_done_q;
    logic [FCNT_W-1:0]  frame_count_q;
    word_t              word_view;

    assign mode  = mode_e'(sel_mode);
    // A cleared cycle drops its bit, so it never enables a write.
    assign wr_en = din_valid & ~clear;
    assign idx   = (mode == MODE_EXPLICIT) ? sel_in : cnt;

    // Group decode from index[3:2].
    demux_1to4 u_grp (
        .idx  (idx[3:2]),
        .en   (wr_en),
        .we_c (grp_we)
    );

    // Bit-within-group decode, one decoder per group.
    for (genvar g = 0; g < N_GRP; g++) begin : g_bit
        demux_1to4 u_bit (
            .idx  (idx[1:0]),
            .en   (grp_we[g]),
            .we_c (we_c[g*GRP_W +: GRP_W])
        );
    end

    // Next-state: clear beats mode, explicit mode beats scanning.
    always_comb begin
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        word_nxt  = word_q;
        commit_c  = 1'b0;
        if (clear) begin
            cnt_nxt   = '0;
            shreg_nxt = RESET_VAL;
        end else if (mode == MODE_EXPLICIT) begin
            cnt_nxt  = '0;
            word_nxt = (word_q & ~we_c) | (we_c & {N_CH{din}});
        end else if (din_valid) begin
            shreg_nxt = (shreg & ~we_c) | (we_c & {N_CH{din}});
            cnt_nxt   = cnt + SEL_W'(1);
            if (cnt == SEL_W'(N_CH - 1)) begin
                commit_c = 1'b1;
                word_nxt = shreg_nxt;
            end
        end
    end

    // State registers; frame_done and frame_count trail the commit by one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            shreg         <= RESET_VAL;
            word_q        <= RESET_VAL;
            commit_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            cnt          <= cnt_nxt;
            shreg        <= shreg_nxt;
            word_q       <= word_nxt;
            commit_q     <= commit_c;
            frame_done_q <= commit_q;
            if (commit_q) begin
                frame_count_q <= frame_count_q + FCNT_W'(1);
            end
        end
    end

    assign word_view   = word_t'(word_q);
    assign sel_out     = cnt;
    assign A           = word_view.a;
    assign B           = word_view.b;
    assign C           = word_view.c;
    assign D           = word_view.d;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

endmodule

// File: doc/demux_16ch_scan.md
Name: demux_16ch_scan

Overview:
Receive-side counterpart of the 16-to-1 bit mux. It rebuilds a 16-bit word, arranged as four 4-bit groups A/B/C/D, from a time-multiplexed serial line. It drives the scan index (sel_out) back to the remote mux select, captures one bit per valid cycle into a shadow register, and updates all outputs atomically at frame end. An explicit-address mode allows single-bit writes without scanning.

Parameters:
RESET_VAL, 16'h0000, value loaded into the shadow register and into {D,C,B,A} on reset.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
din  input  1  serial bit from the remote mux output line
din_valid  input  1  din is valid this cycle
sel_mode  input  1  0 = auto-scan, 1 = explicit address
sel_in  input  4  bit index for explicit mode
clear  input  1  abort the current frame and restart at index 0
sel_out  output  4  current scan index, drives the remote mux sel
A  output  4  bits 0..3 of the word
B  output  4  bits 4..7
C  output  4  bits 8..11
D  output  4  bits 12..15
frame_done  output  1  one-cycle pulse after a complete frame is committed
frame_count  output  8  number of committed frames, wraps 255->0

Behaviour:
- Index mapping, identical to the transmit mux: index i selects group i[3:2] (0=A, 1=B, 2=C, 3=D) and bit i[1:0] within that group.
- Reset (rst=1 at a clk edge):
  - {D,C,B,A} and the shadow register load RESET_VAL.
  - cnt, sel_out, frame_done and frame_count go to 0.
  - rst overrides every other input.
- sel_out is equal to the registered scan counter cnt at all times.
- Auto mode (sel_mode=0), on each cycle with din_valid=1:
  - shreg[cnt] <= din and cnt <= cnt+1, wrapping 15->0.
  - When cnt==15: {D,C,B,A} <= {din, shreg[14:0]} at the same edge. On the next edge frame_done=1 for exactly one cycle, and frame_count increments at that same edge.
  - Outputs never show a partial frame.
- din_valid=0: no state changes. The frame may be stretched by any number of idle cycles.
- Explicit mode (sel_mode=1):
  - On din_valid=1, output bit sel_in <= din directly, visible one cycle later.
  - cnt is forced to 0 and the shadow register is untouched.
  - frame_done is never asserted.
- Mode change mid-frame: the partial frame is discarded and cnt becomes 0 at the first edge with sel_mode=1. The next auto frame restarts at index 0.
- clear=1:
  - Sets cnt <= 0 and shreg <= RESET_VAL.
  - Output registers and frame_count are unchanged.
  - clear takes priority over din_valid in the same cycle, and that bit is dropped.
  - clear together with cnt==15 and din_valid: no commit, no frame_done.
- Back-to-back frames with din_valid held high: a commit every 16 cycles, and frame_done pulses spaced 16 cycles apart.
- Latency:
  - Last bit in to outputs updated: 1 cycle.
  - Last bit in to frame_done asserted: 2 cycles.

Decomposition:
- Shared package constants:
  - N_CH=16
  - SEL_W=4
  - N_GRP=4
  - GRP_W=4
  - FCNT_W=8
- Natural sub-module demux_1to4, the mirror of the 4-to-1 mux:
  - Inputs: a 2-bit index and an enable.
  - Output: a one-hot 4-bit write enable.
  - One instance decodes the group (index[3:2]) and four instances decode the bit within each group.
  - The top level holds cnt, shreg, the output registers, frame_done and frame_count.

Test Plan:
- Reset with RESET_VAL=16'hA5C3 -> A=3, B=C, C=5, D=A, sel_out=0, frame_done=0, frame_count=0.
- Auto mode, stream bits of 16'h1234 LSB first with din_valid held high -> sel_out steps 0..15; A,B,C,D stay at reset values through index 14; after index 15, A=4, B=3, C=2, D=1; frame_done pulses one cycle later; frame_count=1.
- Same frame with random din_valid gaps, then a second frame 16'hFFFF -> identical commit timing relative to the valid bits; A=B=C=D=F; frame_count=2.
- Start a frame, assert clear after 7 bits, then send a full frame 16'h0F0F -> no commit after the aborted 7 bits; the next 16 bits commit 16'h0F0F; one frame_done pulse only.
- Explicit mode, sel_in=9 with din=1, then sel_in=2 with din=1, starting from 0 -> C=4'b0010 and A=4'b0100 one cycle after each write; frame_done stays 0; sel_out=0.
- Switch to sel_mode=1 at index 5 of a frame, back to 0, then stream a full frame -> the partial frame is lost, the scan restarts at index 0, and exactly one commit happens, after 16 bits.
